// File: rtl/spi_pkg.sv
// Shared definitions for the oversampled SPI word slave: mode encodings,
// FSM state type and the bit-order helper.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  function automatic logic [5:0] bit_idx(input logic [5:0] cnt,
                                         input logic [5:0] width,
                                         input logic       msb_first);
    return msb_first ? (width - 6'd1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into clk and produces registered edge strobes,
// all aligned to the same pipeline stage as mosi_s.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic SCLK_IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_act,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_sclk;
  logic w_cs;
  logic w_mosi;
  logic r_sclk_d;
  logic r_cs_d;
  logic r_sclk_rise;
  logic r_sclk_fall;
  logic r_cs_fall;
  logic r_cs_rise;
  logic r_cs_act;
  logic r_mosi;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // sclk resets to its idle level so release of reset never looks like an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= SCLK_IDLE;
      r_cs_d      <= 1'b1;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_act    <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      r_sclk_rise <= w_sclk & ~r_sclk_d;
      r_sclk_fall <= ~w_sclk & r_sclk_d;
      r_cs_fall   <= ~w_cs & r_cs_d;
      r_cs_rise   <= w_cs & ~r_cs_d;
      r_cs_act    <= ~w_cs;
      r_mosi      <= w_mosi;
    end
  end

  assign sclk_rise = r_sclk_rise;
  assign sclk_fall = r_sclk_fall;
  assign cs_fall   = r_cs_fall;
  assign cs_rise   = r_cs_rise;
  assign cs_act    = r_cs_act;
  assign mosi_s    = r_mosi;

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave with configurable width/mode/bit order, oversampled in clk.
// state     | meaning
// ST_IDLE   | chip select released, miso held low
// ST_ACTIVE | framed by cs_n, shifting words
module spi_word_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             underrun,
  input  logic             flag_clr,
  output logic             busy
);

  localparam int         CW        = $clog2(WIDTH);
  localparam logic [1:0] MODE      = {1'(CPOL), 1'(CPHA)};
  localparam logic       LEAD_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE1);
  localparam logic       SAMP_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_act, w_mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .SCLK_IDLE  (1'(CPOL))
  ) u_pin_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sclk_rise(w_sclk_rise),
    .sclk_fall(w_sclk_fall),
    .cs_fall  (w_cs_fall),
    .cs_rise  (w_cs_rise),
    .cs_act   (w_cs_act),
    .mosi_s   (w_mosi_s)
  );

  spi_state_t       r_state, w_next;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_tx_hold;
  logic             r_rx_valid, r_tx_ready, r_overrun, r_underrun, r_miso;

  logic             w_lead, w_trail, w_sample, w_shift, w_active, w_abort;
  logic             w_samp_ok, w_shift_ok, w_last, w_rx_done, w_word_start;
  logic             w_under_set, w_tx_wr;
  logic [CW-1:0]    w_bit_idx, w_idx0;
  logic [WIDTH-1:0] w_tx_load, w_rx_word;

  assign w_lead   = LEAD_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_trail  = LEAD_RISE ? w_sclk_fall : w_sclk_rise;
  assign w_sample = SAMP_LEAD ? w_lead : w_trail;
  assign w_shift  = SAMP_LEAD ? w_trail : w_lead;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_abort   = w_active && w_cs_rise;
  assign w_last    = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_samp_ok = w_active && w_sample && !w_cs_rise;
  assign w_rx_done = w_samp_ok && w_last;
  // In CPHA=0 the shift edge right after a word boundary carries no new bit
  assign w_shift_ok = w_active && w_shift && !w_cs_rise &&
                      !(SAMP_LEAD && (r_bit_cnt == '0));
  assign w_word_start = (!w_active && w_cs_fall) || w_rx_done;

  assign w_bit_idx = CW'(bit_idx(6'(r_bit_cnt), 6'(WIDTH), 1'(MSB_FIRST)));
  assign w_idx0    = CW'(bit_idx(6'd0, 6'(WIDTH), 1'(MSB_FIRST)));

  assign w_tx_load   = !r_tx_ready ? r_tx_hold : (tx_valid ? tx_data : '0);
  assign w_under_set = w_word_start && r_tx_ready && !tx_valid;
  assign w_tx_wr     = tx_valid && r_tx_ready && !w_word_start;

  always_comb begin
    w_rx_word            = r_rx_shift;
    w_rx_word[w_bit_idx] = w_mosi_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_shift <= '0;
      r_tx_hold  <= '0;
      r_tx_ready <= 1'b1;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      if (w_word_start) begin
        r_tx_shift <= w_tx_load;
        r_tx_ready <= 1'b1;
      end else if (w_tx_wr) begin
        r_tx_hold  <= tx_data;
        r_tx_ready <= 1'b0;
      end

      if (w_word_start && SAMP_LEAD)   r_miso <= w_tx_load[w_idx0];
      else if (!w_active || w_abort)   r_miso <= 1'b0;
      else if (w_shift_ok)             r_miso <= r_tx_shift[w_bit_idx];

      if (!w_active || w_abort) begin
        r_bit_cnt <= '0;
      end else if (w_samp_ok) begin
        r_rx_shift[w_bit_idx] <= w_mosi_s;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
      end

      // A consume in the completion cycle frees the slot for the new word
      if (w_rx_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_rx_done && r_rx_valid && !rx_ready) r_overrun <= 1'b1;
      else if (flag_clr)                        r_overrun <= 1'b0;

      if (w_under_set)   r_underrun <= 1'b1;
      else if (flag_clr) r_underrun <= 1'b0;
    end
  end

  assign miso     = r_miso;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;
  assign busy     = w_cs_act;

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench: four WIDTH=8 instances (modes 0..3) and one WIDTH=12 LSB-first
// instance, each driven by its own bit-banged SPI master.
`timescale 1ns/1ps
module tb_spi_word_slave;

  localparam time TCLK = 10ns;
  localparam time H    = 80ns;

  logic        clk;
  logic        rst;
  logic [4:0]  sck_v;
  logic [4:0]  csv;
  logic [4:0]  mosi_v;
  logic [4:0]  txv;
  logic [31:0] tx_data;
  logic        rx_ready;
  logic        flag_clr;

  logic        miso_v     [5];
  logic        tx_ready_v [5];
  logic        rx_valid_v [5];
  logic        ovr_v      [5];
  logic        und_v      [5];
  logic        busy_v     [5];
  logic [7:0]  rxd8       [4];
  logic [11:0] rxd12;

  int n_chk = 0;
  int n_err = 0;
  int rv_cnt [5];
  logic rv_prev [5];

  initial clk = 1'b0;
  always #(TCLK/2) clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_word_slave #(
      .WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst(rst), .spi_clk(sck_v[g]), .cs_n(csv[g]), .mosi(mosi_v[g]),
      .miso(miso_v[g]), .tx_data(tx_data[7:0]), .tx_valid(txv[g]),
      .tx_ready(tx_ready_v[g]), .rx_data(rxd8[g]), .rx_valid(rx_valid_v[g]),
      .rx_ready(rx_ready), .overrun(ovr_v[g]), .underrun(und_v[g]),
      .flag_clr(flag_clr), .busy(busy_v[g])
    );
  end

  spi_word_slave #(
    .WIDTH(12), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)
  ) u_dut12 (
    .clk(clk), .rst(rst), .spi_clk(sck_v[4]), .cs_n(csv[4]), .mosi(mosi_v[4]),
    .miso(miso_v[4]), .tx_data(tx_data[11:0]), .tx_valid(txv[4]),
    .tx_ready(tx_ready_v[4]), .rx_data(rxd12), .rx_valid(rx_valid_v[4]),
    .rx_ready(rx_ready), .overrun(ovr_v[4]), .underrun(und_v[4]),
    .flag_clr(flag_clr), .busy(busy_v[4])
  );

  initial for (int i = 0; i < 5; i++) begin rv_cnt[i] = 0; rv_prev[i] = 1'b0; end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid_v[i] && !rv_prev[i]) rv_cnt[i] <= rv_cnt[i] + 1;
      rv_prev[i] <= rx_valid_v[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int k, input int cpha, input int msb, input int width,
                      input int nbits, input logic [31:0] word, output logic [31:0] got);
    int idx;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = (msb != 0) ? (width - 1 - i) : i;
      if (cpha == 0) begin
        mosi_v[k] = word[idx];
        #(H);
        got[idx] = miso_v[k];
        sck_v[k] = ~sck_v[k];
        #(H);
        sck_v[k] = ~sck_v[k];
      end else begin
        #(H);
        sck_v[k] = ~sck_v[k];
        mosi_v[k] = word[idx];
        #(H);
        got[idx] = miso_v[k];
        sck_v[k] = ~sck_v[k];
      end
    end
  endtask

  task automatic cs_end(input int k);
    #(H);
    csv[k] = 1'b1;
    #(2 * H);
  endtask

  task automatic pulse_rx_ready();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic pulse_flag_clr();
    @(posedge clk); #1 flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got, got2;
    int base;
    rst = 1'b0; sck_v = 5'b01100; csv = 5'b11111; mosi_v = '0; txv = '0;
    tx_data = '0; rx_ready = 1'b0; flag_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_miso",     32'(miso_v[0]),     32'h0);
    check_val("rst_tx_ready", 32'(tx_ready_v[0]), 32'h1);
    check_val("rst_rx_data",  32'(rxd8[0]),       32'h0);
    check_val("rst_rx_valid", 32'(rx_valid_v[0]), 32'h0);
    check_val("rst_overrun",  32'(ovr_v[0]),      32'h0);
    check_val("rst_underrun", 32'(und_v[0]),      32'h0);
    check_val("rst_busy",     32'(busy_v[0]),     32'h0);

    // Preload 0xAB everywhere and keep offering it so word starts never starve
    tx_data = 32'hAB; txv = 5'b11111;
    repeat (3) @(posedge clk); #1;
    check_val("hold_full", 32'(tx_ready_v[0]), 32'h0);

    for (int k = 0; k < 4; k++) begin
      base = rv_cnt[k];
      csv[k] = 1'b0;
      xfer(k, k % 2, 1, 8, 8, 32'hCB, got);
      cs_end(k);
      check_val($sformatf("m%0d_miso_word", k), got, 32'hAB);
      check_val($sformatf("m%0d_rx_data", k), 32'(rxd8[k]), 32'hCB);
      check_val($sformatf("m%0d_rx_valid", k), 32'(rx_valid_v[k]), 32'h1);
      check_val($sformatf("m%0d_rv_pulses", k), 32'(rv_cnt[k] - base), 32'h1);
      check_val($sformatf("m%0d_overrun", k), 32'(ovr_v[k]), 32'h0);
      check_val($sformatf("m%0d_underrun", k), 32'(und_v[k]), 32'h0);
      check_val($sformatf("m%0d_busy_idle", k), 32'(busy_v[k]), 32'h0);
      pulse_rx_ready(); #1;
      check_val($sformatf("m%0d_consumed", k), 32'(rx_valid_v[k]), 32'h0);
    end

    csv[4] = 1'b0;
    xfer(4, 0, 0, 12, 12, 32'h5A3, got);
    cs_end(4);
    check_val("w12_rx_data",   32'(rxd12), 32'h5A3);
    check_val("w12_rx_valid",  32'(rx_valid_v[4]), 32'h1);
    check_val("w12_miso_word", got, 32'h0AB);
    pulse_rx_ready();

    csv[0] = 1'b0;
    xfer(0, 0, 1, 8, 8, 32'h3C, got);
    xfer(0, 0, 1, 8, 8, 32'hC3, got2);
    cs_end(0);
    check_val("ovr_rx_data",  32'(rxd8[0]), 32'h3C);
    check_val("ovr_rx_valid", 32'(rx_valid_v[0]), 32'h1);
    check_val("ovr_flag",     32'(ovr_v[0]), 32'h1);
    check_val("ovr_no_under", 32'(und_v[0]), 32'h0);
    check_val("ovr_miso_w2",  got2, 32'hAB);
    pulse_flag_clr(); #1;
    check_val("ovr_cleared",  32'(ovr_v[0]), 32'h0);
    pulse_rx_ready();

    // Stop offering TX data; the aborted frame consumes the last held word
    txv[0] = 1'b0;
    base = rv_cnt[0];
    csv[0] = 1'b0;
    xfer(0, 0, 1, 8, 3, 32'hFF, got);
    check_val("abort_busy", 32'(busy_v[0]), 32'h1);
    cs_end(0);
    check_val("abort_rx_valid", 32'(rx_valid_v[0]), 32'h0);
    check_val("abort_underrun", 32'(und_v[0]), 32'h0);
    check_val("abort_miso",     32'(miso_v[0]), 32'h0);
    check_val("abort_tx_ready", 32'(tx_ready_v[0]), 32'h1);
    csv[0] = 1'b0;
    xfer(0, 0, 1, 8, 8, 32'h0F, got);
    cs_end(0);
    check_val("after_abort_rx", 32'(rxd8[0]), 32'h0F);
    check_val("after_abort_rv", 32'(rv_cnt[0] - base), 32'h1);
    check_val("under_miso",     got, 32'h00);
    check_val("under_flag",     32'(und_v[0]), 32'h1);
    pulse_rx_ready();
    pulse_flag_clr(); #1;
    check_val("under_cleared",  32'(und_v[0]), 32'h0);

    // tx_valid only in the cycle the synchronised cs_n fall is seen
    @(posedge clk); #1 csv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 tx_data = 32'h96; txv[0] = 1'b1;
    @(posedge clk); #1 txv[0] = 1'b0;
    check_val("direct_tx_ready", 32'(tx_ready_v[0]), 32'h1);
    tx_data = 32'h5E; txv[0] = 1'b1;
    @(posedge clk); #1 txv[0] = 1'b0;
    xfer(0, 0, 1, 8, 8, 32'h81, got);
    cs_end(0);
    check_val("direct_miso",     got, 32'h96);
    check_val("direct_underrun", 32'(und_v[0]), 32'h0);
    check_val("direct_rx_data",  32'(rxd8[0]), 32'h81);

    // Leave rx_valid set and start an under-fed frame, then reset mid-word
    csv[0] = 1'b0;
    xfer(0, 0, 1, 8, 3, 32'hA0, got);
    check_val("pre_rst_underrun", 32'(und_v[0]), 32'h1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_miso",     32'(miso_v[0]),     32'h0);
    check_val("mid_rst_tx_ready", 32'(tx_ready_v[0]), 32'h1);
    check_val("mid_rst_rx_data",  32'(rxd8[0]),       32'h0);
    check_val("mid_rst_rx_valid", 32'(rx_valid_v[0]), 32'h0);
    check_val("mid_rst_overrun",  32'(ovr_v[0]),      32'h0);
    check_val("mid_rst_underrun", 32'(und_v[0]),      32'h0);
    check_val("mid_rst_busy",     32'(busy_v[0]),     32'h0);
    csv[0] = 1'b1;
    #(H);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_word_slave.md
# spi_word_slave

Parametrised SPI slave successor to the fixed 8-bit, single-mode reader. It adds configurable word width, all four CPOL/CPHA modes, selectable bit order, a chip-select framing input, ready/valid handshakes on both data directions, and sticky overrun/underrun flags. It sits between an external SPI master and the system-clock fabric. All SPI pins are oversampled in the `clk` domain, with no logic clocked by `spi_clk`.

## Interface
- `WIDTH`, 8: bits per SPI word (2..32).
- `CPOL`, 0: idle level of `spi_clk`.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `MSB_FIRST`, 1: 1 = MSB shifted first on both MOSI and MISO.
- `SYNC_STAGES`, 2: synchroniser depth for `spi_clk`, `cs_n` and `mosi` (≥2).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `spi_clk`  in  1  SPI serial clock (asynchronous).
- `cs_n`  in  1  chip select, active low (asynchronous).
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master, registered.
- `tx_data`  in  WIDTH  next word to transmit.
- `tx_valid`  in  1  `tx_data` offered.
- `tx_ready`  out  1  TX holding register empty.
- `rx_data`  out  WIDTH  last received word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `overrun`  out  1  sticky: a word arrived while `rx_valid` was high.
- `underrun`  out  1  sticky: a word started with an empty TX holding register.
- `flag_clr`  in  1  clears both sticky flags.
- `busy`  out  1  `cs_n` (synchronised) asserted.

## Operation
- Reset values: `miso`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `overrun`=0, `underrun`=0, `busy`=0.
- Edges are derived from the synchronised `spi_clk`:
  - Leading edge = rising if `CPOL`=0, falling if `CPOL`=1.
  - Sample edge = leading if `CPHA`=0, trailing if `CPHA`=1.
  - Shift edge = the other edge.
- FSM:
  - IDLE → ACTIVE on synchronised `cs_n` falling.
  - ACTIVE → IDLE on synchronised `cs_n` rising, from any bit position.
- Word start (entry to ACTIVE, or bit counter wrapping to 0):
  - Load the TX shift register from the holding register and set `tx_ready`.
  - If the holding register is empty, load all-zeros and set `underrun`.
  - If `CPHA`=0, drive the first bit onto `miso` in the same cycle.
  - If `CPHA`=1, drive the first bit on the first shift (leading) edge.
- Sample edge: shift the synchronised `mosi` into the RX shift register and increment the bit counter (`$clog2(WIDTH)` bits).
- Shift edge: present the next TX bit. In `CPHA`=0, the shift edge following the final sample is ignored.
- WIDTH-th sample:
  - If `rx_valid`=0: `rx_data` ← the assembled word and `rx_valid`←1 on the next cycle.
  - If `rx_valid`=1: the word is dropped, `rx_data` is unchanged and `overrun`←1.
  - In both cases the counter wraps to 0.
- `rx_valid` clears on `rx_valid && rx_ready`. If a word completes in the same cycle as a consume, the new word is stored and no overrun is raised.
- `tx_valid && tx_ready` writes the holding register and clears `tx_ready`. If a word starts in the same cycle as a write, the incoming `tx_data` is loaded directly and no underrun is raised.
- `cs_n` rising mid-word: discard the partial RX word, reset the counter, `miso`←0, and raise no flags. The TX word already loaded is consumed, not replayed.
- `miso` = 0 whenever IDLE.
- `flag_clr` has priority below a same-cycle set: a set in that cycle wins.

## Timing
- Pin-to-internal latency is SYNC_STAGES+1 `clk` cycles (sync plus edge-detect register).
- Requirement: each `spi_clk` half-period ≥ SYNC_STAGES+2 `clk` cycles. `cs_n` falling must precede the first `spi_clk` edge by the same margin.
- Last sample edge → `rx_valid` high is SYNC_STAGES+2 cycles.
- `rx_valid`/`tx_ready` change one cycle after the handshake.
- `miso` update is SYNC_STAGES+2 cycles after the shift edge at the pin. The master samples on the opposite half-period.

## Structure
- `spi_pkg`: mode constants (`SPI_MODE0..3` as {CPOL,CPHA}) and a function returning the bit index for a given count and `MSB_FIRST`.
- Sub-module `spi_pin_sync`: SYNC_STAGES-deep synchroniser for the 3 inputs plus registered edge detect. Outputs: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`, `cs_act`, `mosi_s`.
- Top-level: FSM, counter, shift registers, holding register, flags.

## Test plan
- Mode 0, WIDTH=8, MSB first: master sends 0xCB while `tx_data`=0xAB is preloaded → `rx_data`=0xCB with one `rx_valid` assertion; master receives 0xAB; no flags set.
- Repeat the same bytes in modes 1, 2 and 3 (CPOL/CPHA sweep) → identical data in both directions each time.
- WIDTH=12, `MSB_FIRST`=0: master sends 0x5A3 LSB first → `rx_data`=0x5A3.
- Two back-to-back words with `rx_ready` held 0 → first word retained, second dropped, `overrun`=1; `flag_clr` → `overrun`=0.
- Empty TX holding register at word start → master reads 0x00 and `underrun`=1. Separately, `tx_valid` on the exact start cycle → word transmitted and `underrun`=0.
- `cs_n` deasserted after 3 bits, then a full 0x0F frame → `rx_valid` only for 0x0F. Then reset asserted mid-frame → all outputs return to reset values immediately.
